// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: reset PC, NOP encoding, fetch exception codes,
// fetch FSM encoding and the IF/ID payload layout.
package cpu_pkg;

  localparam logic [63:0] RESET_PC_DEFAULT       = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_INSTR              = 32'h0000_0013;
  localparam logic [3:0]  EXC_INSTR_MISALIGNED   = 4'd0;
  localparam logic [3:0]  EXC_INSTR_ACCESS_FAULT = 4'd1;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        exc_en;
    logic [3:0]  exc_code;
    logic [63:0] exc_val;
  } if_entry_t;

  localparam if_entry_t IF_ENTRY_RESET = '{
    pc:       64'h0,
    instr:    NOP_INSTR,
    exc_en:   1'b0,
    exc_code: 4'h0,
    exc_val:  64'h0
  };

endpackage

// File: rtl/if_id_reg.sv
// IF/ID payload register: flush clears valid, load captures a new entry, otherwise holds.
// One-cycle latency; the payload is bit-stable while held so decode can stall indefinitely.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      load,
  input  logic      flush,
  input  if_entry_t entry_dat,
  output logic      entry_vld,
  output if_entry_t entry_q
);

  // Flush only drops the valid bit; the stale payload is never observed by decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_vld <= 1'b0;
      entry_q   <= IF_ENTRY_RESET;
    end else if (flush) begin
      entry_vld <= 1'b0;
    end else if (load) begin
      entry_vld <= 1'b1;
      entry_q   <= entry_dat;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, samples combinational imem into IF/ID, handles redirects
// and halts after a fault entry. One entry per cycle; holds PC and entry while decode stalls.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          XLEN     = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] pc_addr,
  input  logic [31:0]     imem_instr,
  input  logic            imem_exc_en,
  input  logic [3:0]      imem_exc_code,
  input  logic [XLEN-1:0] imem_exc_val,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic            if_exc_en,
  output logic [3:0]      if_exc_code,
  output logic [XLEN-1:0] if_exc_val
);

  logic [63:0]  pc;
  fetch_state_t state;
  logic         advance;
  logic         load;
  logic         flush;
  logic         fault;
  if_entry_t    entry_dat;
  if_entry_t    entry_q;

  assign advance = !if_valid || id_ready;
  assign load    = !redirect_en && (state == RUN) && advance;
  // In HALT the consumed fault entry is retired without a replacement fetch.
  assign flush   = redirect_en || ((state == HALT) && if_valid && id_ready);

  always_comb begin
    fault     = 1'b0;
    entry_dat = '{pc: pc, instr: imem_instr, exc_en: 1'b0, exc_code: 4'h0, exc_val: 64'h0};
    if (pc[1:0] != 2'b00) begin
      fault     = 1'b1;
      entry_dat = '{pc: pc, instr: NOP_INSTR, exc_en: 1'b1,
                    exc_code: EXC_INSTR_MISALIGNED, exc_val: pc};
    end else if (imem_exc_en) begin
      fault     = 1'b1;
      entry_dat = '{pc: pc, instr: NOP_INSTR, exc_en: 1'b1,
                    exc_code: imem_exc_code, exc_val: imem_exc_val};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      state <= RUN;
    end else if (redirect_en) begin
      pc    <= redirect_pc;
      state <= RUN;
    end else if (load) begin
      if (fault) state <= HALT;
      else       pc    <= pc + 64'd4;
    end
  end

  if_id_reg u_if_id_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .flush     (flush),
    .entry_dat (entry_dat),
    .entry_vld (if_valid),
    .entry_q   (entry_q)
  );

  assign pc_addr     = pc;
  assign if_pc       = entry_q.pc;
  assign if_instr    = entry_q.instr;
  assign if_exc_en   = entry_q.exc_en;
  assign if_exc_code = entry_q.exc_code;
  assign if_exc_val  = entry_q.exc_val;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, stall, redirect, faults, wrap and async reset.
module tb_fetch_stage;

  localparam logic [63:0] RST_PC  = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [63:0] FLT_PC  = 64'h0000_0000_8004_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] pc_addr;
  logic [31:0] imem_instr;
  logic        imem_exc_en;
  logic [3:0]  imem_exc_code;
  logic [63:0] imem_exc_val;
  logic        redirect_en = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        id_ready = 1'b1;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        if_exc_en;
  logic [3:0]  if_exc_code;
  logic [63:0] if_exc_val;
  logic        fault_arm = 1'b0;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [63:0] a);
    if (a == RST_PC) return 32'h0050_0093;
    return a[31:0] ^ 32'h0000_0013;
  endfunction

  assign imem_instr    = imem_word(pc_addr);
  assign imem_exc_en   = fault_arm && (pc_addr == FLT_PC);
  assign imem_exc_code = imem_exc_en ? 4'd1 : 4'd0;
  assign imem_exc_val  = imem_exc_en ? FLT_PC : 64'h0;

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_addr       (pc_addr),
    .imem_instr    (imem_instr),
    .imem_exc_en   (imem_exc_en),
    .imem_exc_code (imem_exc_code),
    .imem_exc_val  (imem_exc_val),
    .redirect_en   (redirect_en),
    .redirect_pc   (redirect_pc),
    .id_ready      (id_ready),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .if_exc_en     (if_exc_en),
    .if_exc_code   (if_exc_code),
    .if_exc_val    (if_exc_val)
  );

  task automatic do_redirect(input logic [63:0] target);
    redirect_en = 1'b1;
    redirect_pc = target;
    @(negedge clk);
    redirect_en = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (pc_addr !== RST_PC) $display("FAIL reset_pc: got %h want %h", pc_addr, RST_PC); else passed++;
    checks++; if (if_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", if_valid); else passed++;
    checks++; if (if_instr !== NOP) $display("FAIL reset_instr: got %h want %h", if_instr, NOP); else passed++;
    checks++; if (if_pc !== 64'h0 || if_exc_en !== 1'b0 || if_exc_code !== 4'h0 || if_exc_val !== 64'h0)
      $display("FAIL reset_fields: pc %h exc %b code %h val %h want zeros", if_pc, if_exc_en, if_exc_code, if_exc_val);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== RST_PC || if_instr !== 32'h0050_0093)
      $display("FAIL first_entry: v %b pc %h instr %h want 1 %h 00500093", if_valid, if_pc, if_instr, RST_PC);
    else passed++;
    checks++; if (pc_addr !== RST_PC + 64'd4) $display("FAIL first_pc_next: got %h want %h", pc_addr, RST_PC + 64'd4); else passed++;
  endtask

  task automatic test_stall;
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (if_valid !== 1'b1 || if_pc !== RST_PC || if_instr !== 32'h0050_0093 || pc_addr !== RST_PC + 64'd4)
        $display("FAIL stall_hold%0d: v %b pc %h instr %h addr %h", i, if_valid, if_pc, if_instr, pc_addr);
      else passed++;
    end
    id_ready = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      checks++; if (if_valid !== 1'b1 || if_pc !== RST_PC + 64'(4 * i) || if_instr !== imem_word(RST_PC + 64'(4 * i)))
        $display("FAIL stall_resume%0d: v %b pc %h instr %h want pc %h", i, if_valid, if_pc, if_instr, RST_PC + 64'(4 * i));
      else passed++;
    end
  endtask

  task automatic test_redirect_stalled;
    id_ready = 1'b0;
    do_redirect(64'h8000_0100);
    checks++; if (if_valid !== 1'b0 || pc_addr !== 64'h8000_0100)
      $display("FAIL redirect_flush: v %b addr %h want 0 0000000080000100", if_valid, pc_addr);
    else passed++;
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== 64'h8000_0100 || if_instr !== 32'h8000_0113 || pc_addr !== 64'h8000_0104)
      $display("FAIL redirect_target: v %b pc %h instr %h addr %h", if_valid, if_pc, if_instr, pc_addr);
    else passed++;
    id_ready = 1'b1;
    @(negedge clk);
    checks++; if (if_pc !== 64'h8000_0104) $display("FAIL redirect_next: got %h want 0000000080000104", if_pc); else passed++;
  endtask

  task automatic test_access_fault;
    int bad;
    fault_arm = 1'b1;
    do_redirect(FLT_PC);
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_exc_en !== 1'b1 || if_exc_code !== 4'd1 || if_exc_val !== FLT_PC || if_instr !== NOP)
      $display("FAIL fault_entry: v %b exc %b code %h val %h instr %h", if_valid, if_exc_en, if_exc_code, if_exc_val, if_instr);
    else passed++;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if_valid !== 1'b0 || pc_addr !== FLT_PC) bad++;
    end
    checks++; if (bad != 0) $display("FAIL fault_halt: %0d cycles with valid/pc wrong, want 0", bad); else passed++;
    fault_arm = 1'b0;
    do_redirect(RST_PC);
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== RST_PC || if_exc_en !== 1'b0 || if_instr !== 32'h0050_0093)
      $display("FAIL fault_recover: v %b pc %h exc %b instr %h", if_valid, if_pc, if_exc_en, if_instr);
    else passed++;
  endtask

  task automatic test_misaligned;
    do_redirect(64'h8000_0002);
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_exc_en !== 1'b1 || if_exc_code !== 4'd0 || if_exc_val !== 64'h8000_0002 || if_instr !== NOP)
      $display("FAIL misalign_entry: v %b exc %b code %h val %h instr %h", if_valid, if_exc_en, if_exc_code, if_exc_val, if_instr);
    else passed++;
    @(negedge clk);
    checks++; if (if_valid !== 1'b0 || pc_addr !== 64'h8000_0002)
      $display("FAIL misalign_halt: v %b addr %h want 0 0000000080000002", if_valid, pc_addr);
    else passed++;
    do_redirect(64'h8000_0004);
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== 64'h8000_0004 || if_exc_en !== 1'b0)
      $display("FAIL misalign_recover: v %b pc %h exc %b", if_valid, if_pc, if_exc_en);
    else passed++;
  endtask

  task automatic test_wrap;
    do_redirect(64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge clk);
    checks++; if (if_pc !== 64'hFFFF_FFFF_FFFF_FFFC || pc_addr !== 64'h0)
      $display("FAIL pc_wrap: if_pc %h addr %h want fffffffffffffffc 0", if_pc, pc_addr);
    else passed++;
  endtask

  task automatic test_async_reset;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b0 || pc_addr !== RST_PC || if_instr !== NOP || if_pc !== 64'h0)
      $display("FAIL async_reset: v %b addr %h instr %h pc %h", if_valid, pc_addr, if_instr, if_pc);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== RST_PC || pc_addr !== RST_PC + 64'd4)
      $display("FAIL async_restart: v %b pc %h addr %h", if_valid, if_pc, pc_addr);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect_stalled();
    test_access_fault();
    test_misaligned();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the CPU pipeline, directly upstream of the instruction memory and downstream-facing to decode. Owns the program counter, drives the word address into instruction memory, captures the returned instruction and its fault signals into an IF/ID register, and hands them to decode over a valid/ready handshake. Also handles redirects (branches, jumps, traps, mret), misaligned fetch detection, and fetch suspension after a fault.

## Interface
Parameters:
- RESET_PC, 64'h0000_0000_8000_0000: PC loaded on reset.
- XLEN, 64: address/data width; only 64 is supported.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low (polarity and synchronicity fixed).
- pc_addr  out  64  fetch address to instruction memory; equals internal PC register.
- imem_instr  in  32  instruction word returned combinationally for pc_addr.
- imem_exc_en  in  1  instruction memory fault for pc_addr.
- imem_exc_code  in  4  fault cause (1 = instruction access fault).
- imem_exc_val  in  64  faulting address.
- redirect_en  in  1  redirect request from execute/trap unit.
- redirect_pc  in  64  redirect target.
- id_ready  in  1  decode can accept the IF/ID contents this cycle.
- if_valid  out  1  IF/ID register holds a valid entry.
- if_pc  out  64  PC of entry.
- if_instr  out  32  instruction of entry; NOP (32'h00000013) when entry carries an exception.
- if_exc_en  out  1  entry carries a fetch exception.
- if_exc_code  out  4  0 = instruction address misaligned, 1 = access fault.
- if_exc_val  out  64  value for mtval (faulting PC).

## Operation
- Reset: pc = RESET_PC; if_valid = 0; if_pc = 0; if_instr = 32'h00000013; if_exc_en = 0; if_exc_code = 0; if_exc_val = 0; state = RUN.
- advance = !if_valid || id_ready. The entry is consumed on a cycle with if_valid && id_ready.
- States:
  - RUN: normal fetch.
  - HALT: a fault entry has been loaded; no further fetches until redirect.
- Priority per cycle: redirect > advance > hold.
- Redirect (any state):
  - pc <= redirect_pc.
  - if_valid <= 0, even when decode is not ready; the flushed entry is dropped.
  - state <= RUN.
- RUN, advance, no redirect:
  - Misaligned case (pc[1:0] != 0): load the entry with exc_en = 1, code 0, val = pc, instr = NOP. pc unchanged. state <= HALT. imem signals are ignored.
  - imem fault case (imem_exc_en): load the entry with exc_en = 1, code = imem_exc_code, val = imem_exc_val, instr = NOP. pc unchanged. state <= HALT.
  - Otherwise: load {pc, imem_instr, no exception}; pc <= pc + 4, wrapping modulo 2^64.
  - In every case if_valid <= 1.
- RUN, !advance: hold pc and the entry unchanged. Outputs stay stable while if_valid && !id_ready.
- HALT, no redirect: pc is held. When the fault entry is consumed, if_valid <= 0 and stays 0.
- Fetch is never retried from HALT without a redirect. This keeps a fault from being issued twice.
- if_instr of an exception entry is always NOP; decode must not execute it.

## Timing
- pc_addr is registered; imem is combinational, so instruction, PC and exception are sampled in the same cycle.
- Throughput: 1 entry per cycle while id_ready = 1.
- Reset to first valid entry: first rising edge after rst_n rises loads the entry for RESET_PC; pc becomes RESET_PC + 4.
- Redirect latency:
  - redirect_en high in cycle N: if_valid = 0 in N+1 and pc = target.
  - The target entry is valid in N+2.
- Stall: an entry with if_valid && !id_ready stays bit-identical until consumed or flushed.
- Simultaneous redirect and id_ready: the current entry is consumed by decode, and the stage follows the redirect.
- Async reset mid-operation clears everything immediately, independent of clk.

## Structure
- Shared package cpu_pkg holds:
  - RESET_PC default
  - NOP_INSTR = 32'h00000013
  - EXC_INSTR_MISALIGNED = 4'd0
  - EXC_INSTR_ACCESS_FAULT = 4'd1
  - the fetch state encoding (RUN, HALT)
- One sub-module is natural: if_id_reg, the IF/ID payload register with load/flush/hold controls.
- PC next-state logic and the FSM stay in fetch_stage.

## Test plan
- Reset release with id_ready = 1, imem returning 32'h00500093 at 0x8000_0000 → first entry pc = 0x8000_0000, instr = 32'h00500093; pc_addr = 0x8000_0004 the next cycle.
- id_ready held low for 3 cycles → if_pc/if_instr unchanged, pc_addr unchanged; on release, entries continue at +4 with no gap or duplicate.
- redirect_en with redirect_pc = 0x8000_0100 while decode is stalled → next cycle if_valid = 0, pc_addr = 0x8000_0100; following cycle entry pc = 0x8000_0100.
- imem_exc_en = 1, code 1, val = 0x8004_0000 → single entry with exc_en = 1, code 1, exc_val = 0x8004_0000, instr = NOP. After consumption if_valid stays 0 for 10 cycles, until redirect to 0x8000_0000 resumes fetch.
- redirect_pc = 0x8000_0002 → entry exc_en = 1, code 0, exc_val = 0x8000_0002, HALT entered; a later redirect to 0x8000_0004 recovers.
- rst_n pulsed low mid-stream → outputs immediately at reset values; fetch restarts at RESET_PC.
